vjtag_tap_regs: RTL and testbench

JTAG instruction and data register bank that sits directly downstream of the TAP state decoder. It consumes the decoder's per-state strobes, its `tck_rise` enable and its flopped TDI. It returns `tdo_mux` and `bypass` to the decoder's TDO stage, and exposes a USER data register to the core through capture and update strobes. Everything runs in the fast `clk` domain; TCK is never used as a clock.

---
 rtl/vjtag_tap_regs.sv | 125 ++++++++++++
 tb/tb_vjtag_tap_regs.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vjtag_tap_regs.sv
// JTAG instruction/data register bank clocked by clk, using the TAP decoder's tck_rise enable.
// Define VJTAG_IDCODE_EN to implement the IDCODE instruction; otherwise opcode 1 decodes as BYPASS.
module vjtag_tap_regs #(
    parameter int          IR_W       = 4,
    parameter int          USER_W     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic              clk,
    input  logic              trst_n,
    input  logic              tck_rise,
    input  logic              tdi_r1,
    input  logic              captureDR,
    input  logic              shiftDR,
    input  logic              updateDR,
    input  logic              captureIR,
    input  logic              shiftIR,
    input  logic              updateIR,
    input  logic [USER_W-1:0] usr_cap_data,
    output logic              tdo_mux,
    output logic              bypass,
    output logic [IR_W-1:0]   ir_out,
    output logic              usr_cap_stb,
    output logic [USER_W-1:0] usr_upd_data,
    output logic              usr_upd_stb
);

`ifdef VJTAG_IDCODE_EN
    localparam bit              IDCODE_EN = 1'b1;
    localparam logic [IR_W-1:0] IR_RST    = IR_W'(1);
`else
    localparam bit              IDCODE_EN = 1'b0;
    localparam logic [IR_W-1:0] IR_RST    = '1;
`endif

    localparam logic [IR_W-1:0]   OP_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0]   OP_USER   = IR_W'(2);
    localparam logic [USER_W-1:0] IDCODE_DR = USER_W'(IDCODE_VAL);

    localparam int P_CDR = 5;
    localparam int P_SDR = 4;
    localparam int P_UDR = 3;
    localparam int P_CIR = 2;
    localparam int P_SIR = 1;
    localparam int P_UIR = 0;

    logic [5:0]        pend_q, pend_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_sh_q, ir_sh_d;
    logic              ir_path_q, ir_path_d;
    logic [USER_W-1:0] dr_sh_q, dr_sh_d;
    logic [USER_W-1:0] usr_upd_q, usr_upd_d;
    logic              is_idcode, is_user;
    logic              cap_stb, upd_stb;

    always_comb begin
        is_idcode = IDCODE_EN && (ir_q == OP_IDCODE);
        is_user   = (ir_q == OP_USER);

        // Flags are captured on the tck_rise cycle and acted on the following cycle.
        pend_d    = tck_rise ? {captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR} : 6'b0;
        ir_d      = ir_q;
        ir_sh_d   = ir_sh_q;
        ir_path_d = ir_path_q;
        dr_sh_d   = dr_sh_q;
        usr_upd_d = usr_upd_q;
        cap_stb   = 1'b0;
        upd_stb   = 1'b0;

        if (pend_q[P_CIR]) begin
            ir_sh_d   = IR_W'(2'b01);
            ir_path_d = 1'b1;
        end
        if (pend_q[P_SIR]) begin
            ir_sh_d = {tdi_r1, ir_sh_q[IR_W-1:1]};
        end
        if (pend_q[P_UIR]) begin
            ir_d = ir_sh_q;
        end
        if (pend_q[P_CDR]) begin
            ir_path_d = 1'b0;
            if (is_idcode) begin
                dr_sh_d = IDCODE_DR;
            end else if (is_user) begin
                dr_sh_d = usr_cap_data;
                cap_stb = 1'b1;
            end else begin
                dr_sh_d = '0;
            end
        end
        if (pend_q[P_SDR]) begin
            dr_sh_d = {tdi_r1, dr_sh_q[USER_W-1:1]};
        end
        if (pend_q[P_UDR] && is_user) begin
            usr_upd_d = dr_sh_q;
            upd_stb   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!trst_n) begin
            pend_q    <= '0;
            ir_q      <= IR_RST;
            ir_sh_q   <= '0;
            ir_path_q <= 1'b0;
            dr_sh_q   <= '0;
            usr_upd_q <= '0;
        end else begin
            pend_q    <= pend_d;
            ir_q      <= ir_d;
            ir_sh_q   <= ir_sh_d;
            ir_path_q <= ir_path_d;
            dr_sh_q   <= dr_sh_d;
            usr_upd_q <= usr_upd_d;
        end
    end

    // Strobes are masked while reset is low so an interrupted scan never reaches the core.
    assign usr_cap_stb  = cap_stb & trst_n;
    assign usr_upd_stb  = upd_stb & trst_n;
    assign usr_upd_data = usr_upd_q;
    assign tdo_mux      = ir_path_q ? ir_sh_q[0] : dr_sh_q[0];
    assign bypass       = !(is_idcode || is_user);
    assign ir_out       = ir_q;

endmodule

// File: tb/tb_vjtag_tap_regs.sv
// Scoreboard bench for vjtag_tap_regs: expected TDO bits are queued as scans are driven.
module tb_vjtag_tap_regs;
    localparam int          IR_W   = 4;
    localparam int          USER_W = 32;
    localparam logic [31:0] IDV    = 32'h1000_0001;

`ifdef VJTAG_IDCODE_EN
    localparam logic [IR_W-1:0]   IR_RST   = 4'h1;
    localparam logic              BYP_RST  = 1'b0;
    localparam logic [USER_W-1:0] IDCODE_X = IDV;
`else
    localparam logic [IR_W-1:0]   IR_RST   = 4'hF;
    localparam logic              BYP_RST  = 1'b1;
    localparam logic [USER_W-1:0] IDCODE_X = '0;
`endif

    localparam logic [5:0] F_CDR = 6'b100000;
    localparam logic [5:0] F_SDR = 6'b010000;
    localparam logic [5:0] F_UDR = 6'b001000;
    localparam logic [5:0] F_CIR = 6'b000100;
    localparam logic [5:0] F_SIR = 6'b000010;
    localparam logic [5:0] F_UIR = 6'b000001;

    logic              clk = 1'b0;
    logic              trst_n = 1'b0;
    logic              tck_rise = 1'b0;
    logic              tdi_r1 = 1'b0;
    logic              captureDR = 1'b0, shiftDR = 1'b0, updateDR = 1'b0;
    logic              captureIR = 1'b0, shiftIR = 1'b0, updateIR = 1'b0;
    logic [USER_W-1:0] usr_cap_data = '0;
    logic              tdo_mux, bypass, usr_cap_stb, usr_upd_stb;
    logic [IR_W-1:0]   ir_out;
    logic [USER_W-1:0] usr_upd_data;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cap_cnt = 0;
    int   upd_cnt = 0;
    logic exp_q[$];

    vjtag_tap_regs #(.IR_W(IR_W), .USER_W(USER_W), .IDCODE_VAL(IDV)) dut (
        .clk(clk), .trst_n(trst_n), .tck_rise(tck_rise), .tdi_r1(tdi_r1),
        .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
        .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR),
        .usr_cap_data(usr_cap_data), .tdo_mux(tdo_mux), .bypass(bypass),
        .ir_out(ir_out), .usr_cap_stb(usr_cap_stb), .usr_upd_data(usr_upd_data),
        .usr_upd_stb(usr_upd_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (usr_cap_stb === 1'b1) cap_cnt++;
        if (usr_upd_stb === 1'b1) upd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic [5:0] fl);
        {captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR} = fl;
    endtask

    // One TCK rise with the given state flag, followed by enough clk cycles for tdo_mux to settle.
    task automatic tck_step(input logic [5:0] fl, input logic tdi);
        @(posedge clk); #1;
        set_flags(fl);
        tdi_r1   = tdi;
        tck_rise = 1'b1;
        @(posedge clk); #1;
        tck_rise = 1'b0;
        @(posedge clk); #1;
        set_flags(6'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic sample_tdo(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_qempty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {63'd0, tdo_mux}, {63'd0, e});
        end
    endtask

    task automatic ir_scan(input logic [IR_W-1:0] op);
        tck_step(F_CIR, 1'b0);
        for (int i = 0; i < IR_W; i++) exp_q.push_back(i == 0);
        for (int i = 0; i < IR_W; i++) begin
            sample_tdo("ir_tdo");
            tck_step(F_SIR, op[i]);
        end
        tck_step(F_UIR, 1'b0);
    endtask

    task automatic dr_scan(input logic [USER_W-1:0] cap_exp, input logic [USER_W-1:0] din,
                           input int n, input logic chk_byp);
        tck_step(F_CDR, 1'b0);
        for (int i = 0; i < n; i++) exp_q.push_back(cap_exp[i]);
        for (int i = 0; i < n; i++) begin
            sample_tdo("dr_tdo");
            if (chk_byp) check_eq("byp_scan", {63'd0, bypass}, 64'd1);
            tck_step(F_SDR, din[i]);
        end
    endtask

    initial begin
        logic [USER_W-1:0] rnd;

        repeat (3) @(posedge clk);
        #1 trst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_ir", {60'd0, ir_out}, {60'd0, IR_RST});
        check_eq("rst_byp", {63'd0, bypass}, {63'd0, BYP_RST});
        check_eq("rst_tdo", {63'd0, tdo_mux}, 64'd0);
        check_eq("rst_upd", {32'd0, usr_upd_data}, 64'd0);
        check_eq("rst_strobes", cap_cnt + upd_cnt, 64'd0);

        // First DR scan after reset.
        dr_scan(IDCODE_X, '0, USER_W, 1'b0);
        check_eq("id_end", {63'd0, tdo_mux}, 64'd0);
        check_eq("id_capstb", cap_cnt, 64'd0);

        ir_scan(4'h2);
        check_eq("user_ir", {60'd0, ir_out}, 64'h2);
        check_eq("user_byp", {63'd0, bypass}, 64'd0);

        usr_cap_data = 32'hA5A5_0F0F;
        dr_scan(32'hA5A5_0F0F, 32'h1234_5678, USER_W, 1'b0);
        check_eq("user_capstb", cap_cnt, 64'd1);
        tck_step(F_UDR, 1'b0);
        check_eq("user_upd", {32'd0, usr_upd_data}, 64'h1234_5678);
        check_eq("user_updstb", upd_cnt, 64'd1);

        ir_scan(4'hF);
        check_eq("byp_ir", {60'd0, ir_out}, 64'hF);
        rnd = $urandom;
        dr_scan('0, rnd, 8, 1'b1);
        tck_step(F_UDR, 1'b0);
        check_eq("byp_after", {63'd0, bypass}, 64'd1);
        check_eq("byp_capstb", cap_cnt, 64'd1);
        check_eq("byp_updstb", upd_cnt, 64'd1);
        check_eq("byp_upd", {32'd0, usr_upd_data}, 64'h1234_5678);

        // USER scan interrupted by reset while its updateDR is pending.
        ir_scan(4'h2);
        usr_cap_data = 32'hDEAD_BEEF;
        dr_scan(32'hDEAD_BEEF, 32'h0000_03FF, 10, 1'b0);
        check_eq("mid_capstb", cap_cnt, 64'd2);
        @(posedge clk); #1;
        set_flags(F_UDR);
        tck_rise = 1'b1;
        @(posedge clk); #1;
        tck_rise = 1'b0;
        set_flags(6'b0);
        trst_n   = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_ir", {60'd0, ir_out}, {60'd0, IR_RST});
        check_eq("mid_byp", {63'd0, bypass}, {63'd0, BYP_RST});
        check_eq("mid_tdo", {63'd0, tdo_mux}, 64'd0);
        check_eq("mid_upd", {32'd0, usr_upd_data}, 64'd0);
        trst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_updstb", upd_cnt, 64'd1);
        check_eq("mid_upd_hold", {32'd0, usr_upd_data}, 64'd0);
        check_eq("mid_capstb_hold", cap_cnt, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
